screen_fade_sequencer: RTL and testbench

- Sits between the pixel-index source of the OLED driver and the combinational game-screen renderers (one per screen id), and feeds the final pixel back to the OLED driver.
- Converts `pixel_index` to `x`/`y` for the renderers.
- Selects the active screen via `screen_sel`.
- On a screen-change request, runs a frame-synchronous fade-out, swap, fade-in sequence by scaling the RGB565 pixel brightness.

---
 rtl/screen_fade_sequencer.sv | 119 +++++++++++
 tb/tb_screen_fade_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_fade_sequencer.sv
// Screen selector with frame-synchronous fade-out / swap / fade-in between game screens.
// Maps the OLED pixel index to x/y and scales the selected renderer's RGB565 pixel by a 0..8 level.
module screen_fade_sequencer #(
  parameter int WIDTH           = 96,
  parameter int HEIGHT          = 64,
  parameter int FRAMES_PER_STEP = 2,
  parameter int NUM_SCREENS     = 10,
  parameter int RESET_SCREEN    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  input  logic        req,
  input  logic [3:0]  req_screen,
  input  logic [15:0] screen_pixel,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic [3:0]  screen_sel,
  output logic [15:0] oled_data,
  output logic        busy,
  output logic        done
);

  localparam int              SCW       = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [SCW-1:0]  STEP_LAST = SCW'(FRAMES_PER_STEP - 1);
  localparam logic [12:0]     NUM_PIX   = 13'(WIDTH * HEIGHT);
  localparam logic [12:0]     WIDTH_IDX = 13'(WIDTH);

  typedef enum logic [1:0] {SHOW, FADE_OUT, SWAP, FADE_IN} state_t;

  state_t         state;
  logic [3:0]     level;
  logic [SCW-1:0] step_cnt;
  logic [3:0]     target;
  logic           step_wrap;
  logic           req_ok;
  logic           in_range;

  // Channel scaling: 9-bit product, then divide by 8 with truncation.
  function automatic logic [5:0] scale_chan(input logic [5:0] c, input logic [3:0] lvl);
    logic [8:0] prod;
    prod = 9'(c) * 9'(lvl);
    return prod[8:3];
  endfunction

  assign x        = 7'(pixel_index % WIDTH_IDX);
  assign y        = 6'(pixel_index / WIDTH_IDX);
  assign in_range = (pixel_index < NUM_PIX);

  always_comb begin
    oled_data = 16'h0000;
    if (in_range) begin
      oled_data = {5'(scale_chan({1'b0, screen_pixel[15:11]}, level)),
                   scale_chan(screen_pixel[10:5], level),
                   5'(scale_chan({1'b0, screen_pixel[4:0]}, level))};
    end
  end

  assign step_wrap = frame_begin && (step_cnt == STEP_LAST);
  assign req_ok    = req && ({28'd0, req_screen} < 32'(NUM_SCREENS)) && (req_screen != screen_sel);

  // Level only moves on a frame_begin cycle, so every frame is drawn at a single level.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SHOW;
      level      <= 4'd8;
      step_cnt   <= '0;
      screen_sel <= 4'(RESET_SCREEN);
      target     <= 4'(RESET_SCREEN);
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SHOW: begin
          if (req_ok) begin
            target   <= req_screen;
            step_cnt <= '0;
            busy     <= 1'b1;
            state    <= FADE_OUT;
          end
        end
        FADE_OUT: begin
          if (step_wrap) begin
            step_cnt <= '0;
            level    <= level - 4'd1;
            if (level == 4'd1) state <= SWAP;
          end else if (frame_begin) begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        SWAP: begin
          // Swap happens while the screen is black, so it is never visible.
          if (frame_begin) begin
            screen_sel <= target;
            step_cnt   <= '0;
            state      <= FADE_IN;
          end
        end
        FADE_IN: begin
          if (step_wrap) begin
            step_cnt <= '0;
            level    <= level + 4'd1;
            if (level == 4'd7) begin
              state <= SHOW;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (frame_begin) begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        default: state <= SHOW;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_fade_sequencer.sv
// Bench for screen_fade_sequencer: scoreboard of expected pixels, one task per scenario.
module tb_screen_fade_sequencer;

  localparam int FPS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_begin;
  logic [12:0] pixel_index;
  logic        req;
  logic [3:0]  req_screen;
  logic [15:0] screen_pixel;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [3:0]  screen_sel;
  logic [15:0] oled_data;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [12:0] coord_q[$];
  logic [15:0] e;
  logic [12:0] ec;

  screen_fade_sequencer #(
    .WIDTH(96), .HEIGHT(64), .FRAMES_PER_STEP(FPS), .NUM_SCREENS(10), .RESET_SCREEN(0)
  ) dut (
    .clk(clk), .reset(reset), .frame_begin(frame_begin), .pixel_index(pixel_index),
    .req(req), .req_screen(req_screen), .screen_pixel(screen_pixel),
    .x(x), .y(y), .screen_sel(screen_sel), .oled_data(oled_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_pix(input logic [15:0] p, input int lvl);
    int r, g, b;
    r = (int'(p[15:11]) * lvl) / 8;
    g = (int'(p[10:5]) * lvl) / 8;
    b = (int'(p[4:0]) * lvl) / 8;
    return {5'(r), 6'(g), 5'(b)};
  endfunction

  function automatic int lvl_after(input int n);
    if (n <= 8 * FPS) return 8 - n / FPS;
    else if (n == 8 * FPS + 1) return 0;
    else return (n - 8 * FPS - 1) / FPS;
  endfunction

  task automatic pulse_frame();
    @(negedge clk); frame_begin = 1'b1;
    @(negedge clk); frame_begin = 1'b0;
  endtask

  task automatic drive_pix(input logic [12:0] idx, input logic [15:0] pix, input logic [15:0] expv);
    pixel_index  = idx;
    screen_pixel = pix;
    exp_q.push_back(expv);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_begin = 1'b0; req = 1'b0; req_screen = 4'd0;
    pixel_index = 13'd0; screen_pixel = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (screen_sel !== 4'd0) begin failures++; $display("FAIL reset_sel: got %0d want 0", screen_sel); end
    drive_pix(13'd0, 16'hF81F, 16'hF81F);
    e = exp_q.pop_front();
    checks++; if (oled_data !== e) begin failures++; $display("FAIL reset_passthru: got %h want %h", oled_data, e); end
  endtask

  task automatic test_coords();
    logic [12:0] idx_t [5] = '{13'd0, 13'd95, 13'd96, 13'd6143, 13'd5000};
    logic [6:0]  x_t   [5] = '{7'd0, 7'd95, 7'd0, 7'd95, 7'd8};
    logic [5:0]  y_t   [5] = '{6'd0, 6'd0, 6'd1, 6'd63, 6'd52};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pixel_index = idx_t[i];
      coord_q.push_back({x_t[i], y_t[i]});
      #1;
      ec = coord_q.pop_front();
      checks++;
      if ({x, y} !== ec) begin
        failures++;
        $display("FAIL coord idx=%0d: got x=%0d y=%0d want x=%0d y=%0d", idx_t[i], x, y, ec[12:6], ec[5:0]);
      end
    end
    @(negedge clk);
    drive_pix(13'd6144, 16'hFFFF, 16'h0000);
    e = exp_q.pop_front();
    checks++; if (oled_data !== e) begin failures++; $display("FAIL out_of_range: got %h want %h", oled_data, e); end
    pixel_index = 13'd0;
  endtask

  task automatic test_full_transition();
    @(negedge clk); req = 1'b1; req_screen = 4'd9;
    @(negedge clk); req = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy_start: got %b want 1", busy); end
    for (int n = 1; n <= 33; n++) begin
      pulse_frame();
      drive_pix(13'd10, 16'hFFFF, model_pix(16'hFFFF, lvl_after(n)));
      e = exp_q.pop_front();
      checks++; if (oled_data !== e) begin failures++; $display("FAIL full_level n=%0d: got %h want %h", n, oled_data, e); end
      checks++; if (busy !== (n < 33)) begin failures++; $display("FAIL full_busy n=%0d: got %b", n, busy); end
      checks++; if (done !== (n == 33)) begin failures++; $display("FAIL full_done n=%0d: got %b", n, done); end
      if (n == 2) begin
        drive_pix(13'd10, 16'h0001, 16'h0000);
        e = exp_q.pop_front();
        checks++; if (oled_data !== e) begin failures++; $display("FAIL scale_l7: got %h want %h", oled_data, e); end
      end
      if (n == 8) begin
        drive_pix(13'd10, 16'hFFFF, 16'h7BEF);
        e = exp_q.pop_front();
        checks++; if (oled_data !== e) begin failures++; $display("FAIL scale_l4_white: got %h want %h", oled_data, e); end
        drive_pix(13'd10, 16'hF81F, 16'h780F);
        e = exp_q.pop_front();
        checks++; if (oled_data !== e) begin failures++; $display("FAIL scale_l4_magenta: got %h want %h", oled_data, e); end
      end
      if (n == 14) begin
        drive_pix(13'd10, 16'h07E0, 16'h00E0);
        e = exp_q.pop_front();
        checks++; if (oled_data !== e) begin failures++; $display("FAIL scale_l1: got %h want %h", oled_data, e); end
      end
      if (n == 16) begin
        checks++; if (screen_sel !== 4'd0) begin failures++; $display("FAIL sel_before_swap: got %0d want 0", screen_sel); end
      end
      if (n == 17) begin
        checks++; if (screen_sel !== 4'd9) begin failures++; $display("FAIL sel_after_swap: got %0d want 9", screen_sel); end
      end
    end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_single: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_end: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); req = 1'b1; req_screen = 4'd5;
    @(negedge clk); req = 1'b0;
    repeat (23) pulse_frame();
    drive_pix(13'd10, 16'hFFFF, model_pix(16'hFFFF, 3));
    e = exp_q.pop_front();
    checks++; if (oled_data !== e) begin failures++; $display("FAIL mid_level3: got %h want %h", oled_data, e); end
    checks++; if (screen_sel !== 4'd5) begin failures++; $display("FAIL mid_sel: got %0d want 5", screen_sel); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    checks++; if (screen_sel !== 4'd0) begin failures++; $display("FAIL rst_mid_sel: got %0d want 0", screen_sel); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    drive_pix(13'd10, 16'hF81F, 16'hF81F);
    e = exp_q.pop_front();
    checks++; if (oled_data !== e) begin failures++; $display("FAIL rst_mid_level: got %h want %h", oled_data, e); end
    repeat (3) pulse_frame();
    drive_pix(13'd10, 16'hFFFF, 16'hFFFF);
    e = exp_q.pop_front();
    checks++; if (oled_data !== e) begin failures++; $display("FAIL rst_no_resume: got %h want %h", oled_data, e); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_no_resume_busy: got %b want 0", busy); end
  endtask

  task automatic test_ignored();
    @(negedge clk); req = 1'b1; req_screen = 4'd0;
    @(negedge clk); req = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_same: got busy=%b want 0", busy); end
    @(negedge clk); req = 1'b1; req_screen = 4'd12;
    @(negedge clk); req = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_range: got busy=%b want 0", busy); end
    @(negedge clk); req = 1'b1; req_screen = 4'd7;
    @(negedge clk); req = 1'b0;
    repeat (3) pulse_frame();
    req = 1'b1; req_screen = 4'd3;
    @(negedge clk); req = 1'b0; #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy_req: got busy=%b want 1", busy); end
    for (int n = 4; n <= 33; n++) begin
      pulse_frame();
      if (n == 17) begin
        checks++; if (screen_sel !== 4'd7) begin failures++; $display("FAIL ign_swap_target: got %0d want 7", screen_sel); end
      end
    end
    #1;
    checks++; if (screen_sel !== 4'd7) begin failures++; $display("FAIL ign_final_sel: got %0d want 7", screen_sel); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL ign_done: got %b want 1", done); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk); req = 1'b1; req_screen = 4'd2; frame_begin = 1'b1;
    @(negedge clk); req = 1'b0; frame_begin = 1'b0; #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL simul_busy: got %b want 1", busy); end
    pulse_frame();
    drive_pix(13'd10, 16'hFFFF, 16'hFFFF);
    e = exp_q.pop_front();
    checks++; if (oled_data !== e) begin failures++; $display("FAIL simul_first: got %h want %h", oled_data, e); end
    pulse_frame();
    drive_pix(13'd10, 16'hFFFF, model_pix(16'hFFFF, 7));
    e = exp_q.pop_front();
    checks++; if (oled_data !== e) begin failures++; $display("FAIL simul_second: got %h want %h", oled_data, e); end
    repeat (31) pulse_frame();
    #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL simul_done: got %b want 1", done); end
    checks++; if (screen_sel !== 4'd2) begin failures++; $display("FAIL simul_sel: got %0d want 2", screen_sel); end
  endtask

  task automatic test_back_to_back();
    int  cnt;
    bit  seen;
    req = 1'b1; req_screen = 4'd4;
    @(negedge clk); req = 1'b0; #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b want 1", busy); end
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 40) begin
      pulse_frame();
      cnt++;
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL b2b_timeout: no done after %0d frames, want 33", cnt); end
    checks++; if (cnt !== 33) begin failures++; $display("FAIL b2b_length: got %0d frames want 33", cnt); end
    checks++; if (screen_sel !== 4'd4) begin failures++; $display("FAIL b2b_sel: got %0d want 4", screen_sel); end
  endtask

  initial begin
    test_reset();
    test_coords();
    test_full_transition();
    test_reset_mid();
    test_ignored();
    test_simultaneous();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
